fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_pc.sv | 45 ++++
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, state encoding and opcode constants for the
// instruction fetch sequencer.
//   PC_W / INST_W   : program counter and instruction widths
//   fetch_state_e   : IDLE / FETCH / HALT
//   OP_*            : opcode field values (inst[15:12])
//   opcode_of()     : extracts the opcode field from an instruction word
package fetch_pkg;

    localparam int PC_W   = 4;
    localparam int INST_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_OUT  = 4'hF;
    localparam logic [3:0] OP_HALT = 4'hE;

    function automatic logic [3:0] opcode_of(input logic [INST_W-1:0] i);
        return i[INST_W-1:INST_W-4];
    endfunction

endpackage

// File: rtl/fetch_pc.sv
// fetch_pc: program counter register.
//   clk, rst_n  : clock, asynchronous active-low reset (loads RESET_PC)
//   load        : load load_addr (highest priority)
//   load_addr   : load target
//   inc         : advance by one, wrapping modulo 2**PC_W
//   pc          : current PC
// With neither load nor inc the PC holds.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 4'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [PC_W-1:0] load_addr,
    input  logic            inc,
    output logic [PC_W-1:0] pc
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + PC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instructions from a combinational program ROM and
// presents them to decode through a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   run               : start request, only honoured in IDLE
//   rom_addr/rom_data : ROM address (== pc) and returned instruction
//   inst, inst_pc     : registered instruction and the address it came from
//   inst_valid        : inst/inst_pc valid; accepted when inst_ready is high
//   redirect(_addr)   : flush and restart fetch at redirect_addr
//   halted            : high while in HALT
//   pc                : current fetch PC
//   redirect_cnt      : saturating count of redirect cycles, present only when
//                       FETCH_SEQ_REDIRECT_CNT_EN is defined
//
// state | meaning
// IDLE  | after reset, nothing fetched, waits for run
// FETCH | fetching one instruction per cycle whenever the output slot is free
// HALT  | halt instruction fetched, no further fetch until a redirect
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 4'h0,
    parameter logic [3:0]      HALT_OPCODE = 4'hE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_addr,
    output logic              halted,
    output logic [PC_W-1:0]   pc
`ifdef FETCH_SEQ_REDIRECT_CNT_EN
    ,
    output logic [7:0]        redirect_cnt
`endif
);

    fetch_state_e      state_d, state_q;
    logic [INST_W-1:0] inst_d, inst_q;
    logic [PC_W-1:0]   inst_pc_d, inst_pc_q;
    logic              inst_valid_d, inst_valid_q;
    logic              halted_d, halted_q;
    logic              pc_load;
    logic              pc_inc;
    logic [PC_W-1:0]   pc_cur;
    logic              slot_open;

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (pc_load),
        .load_addr (redirect_addr),
        .inc       (pc_inc),
        .pc        (pc_cur)
    );

    // The output slot can take a new instruction when it is empty or its
    // current occupant is being accepted this cycle.
    assign slot_open = !inst_valid_q || inst_ready;

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pc_load      = 1'b0;
        pc_inc       = 1'b0;

        if (redirect) begin
            // Flush wins over halt detection and increment; an instruction
            // accepted in this same cycle is simply dropped from the slot.
            inst_valid_d = 1'b0;
            pc_load      = 1'b1;
            state_d      = FETCH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (slot_open) begin
                        inst_d       = rom_data;
                        inst_pc_d    = pc_cur;
                        inst_valid_d = 1'b1;
                        // The halt instruction is presented but the PC stays
                        // on it so a later redirect is the only way forward.
                        if (opcode_of(rom_data) == HALT_OPCODE) begin
                            state_d = HALT;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (inst_valid_q && inst_ready) begin
                        inst_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            halted_q     <= halted_d;
        end
    end

`ifdef FETCH_SEQ_REDIRECT_CNT_EN
    logic [7:0] redirect_cnt_d, redirect_cnt_q;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (redirect && (redirect_cnt_q != 8'hFF)) begin
            redirect_cnt_d = redirect_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_q <= 8'h00;
        end else begin
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`endif

    assign rom_addr   = pc_cur;
    assign pc         = pc_cur;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random stimulus for fetch_sequencer with a
// behavioural reference model and an acceptance scoreboard. The DUT is built
// with HALT_OPCODE = 4'hF so the 0xF-opcode words of the test program halt.
module tb_fetch_sequencer;

    localparam logic [3:0] HALT_OP = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] inst;
    logic [3:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [3:0]  redirect_addr;
    logic        halted;
    logic [3:0]  pc;
`ifdef FETCH_SEQ_REDIRECT_CNT_EN
    logic [7:0]  redirect_cnt;
`endif

    logic [15:0] rom [16];

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    fetch_sequencer #(
        .RESET_PC    (4'h0),
        .HALT_OPCODE (HALT_OP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halted        (halted),
        .pc            (pc)
`ifdef FETCH_SEQ_REDIRECT_CNT_EN
        ,
        .redirect_cnt  (redirect_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Expected accepted instructions: {inst_pc, inst}.
    logic [19:0] exp_q [$];

    // Reference model: mode 0 = waiting for run, 1 = running, 2 = stopped on halt.
    int          m_mode;
    int          m_pc;
    bit          m_valid;
    logic [15:0] m_inst;
    int          m_ipc;
    int          m_rcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_valid = 0;
        m_inst  = 16'h0000;
        m_ipc   = 0;
        m_rcnt  = 0;
    endtask

    // One clock of behaviour for the given inputs, evaluated before the edge.
    task automatic model_cycle(input bit r, input bit rdy, input bit rd, input int a);
        bit accept;
        accept = m_valid && rdy;
        if (accept) exp_q.push_back({4'(m_ipc), m_inst});
        if (rd) begin
            if (m_rcnt < 255) m_rcnt++;
            m_valid = 0;
            m_pc    = a;
            m_mode  = 1;
        end else if (m_mode == 0) begin
            if (r) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!m_valid || rdy) begin
                m_inst  = rom[m_pc];
                m_ipc   = m_pc;
                m_valid = 1;
                if (m_inst[15:12] == HALT_OP) m_mode = 2;
                else m_pc = (m_pc + 1) % 16;
            end
        end else begin
            if (accept) m_valid = 0;
        end
    endtask

    task automatic check_model();
        chk("pc", 32'(pc), 32'(m_pc));
        chk("inst_valid", 32'(inst_valid), 32'(m_valid));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        if (m_valid) begin
            chk("inst", 32'(inst), 32'(m_inst));
            chk("inst_pc", 32'(inst_pc), 32'(m_ipc));
        end
`ifdef FETCH_SEQ_REDIRECT_CNT_EN
        chk("redirect_cnt", 32'(redirect_cnt), 32'(m_rcnt));
`endif
    endtask

    // Called at negedge+1: drive, predict, advance one clock, compare.
    task automatic step(input bit r, input bit rdy, input bit rd, input logic [3:0] a);
        run           = r;
        inst_ready    = rdy;
        redirect      = rd;
        redirect_addr = a;
        model_cycle(r, rdy, rd, int'(a));
        @(negedge clk);
        #1;
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pc"}, 32'(pc), 32'h0);
        chk({tag, "_inst"}, 32'(inst), 32'h0);
        chk({tag, "_inst_pc"}, 32'(inst_pc), 32'h0);
        chk({tag, "_inst_valid"}, 32'(inst_valid), 32'h0);
        chk({tag, "_halted"}, 32'(halted), 32'h0);
`ifdef FETCH_SEQ_REDIRECT_CNT_EN
        chk({tag, "_redirect_cnt"}, 32'(redirect_cnt), 32'h0);
`endif
    endtask

    // Monitor: every handshake the DUT completes must match the next expected item.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL accept_unexpected: got pc=%h inst=%h expected none", inst_pc, inst);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_pc_inst", {12'h0, inst_pc, inst}, {12'h0, e});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
        rom[0] = 16'h1C0A; rom[1] = 16'h1E0B; rom[2] = 16'h120A; rom[3] = 16'h140A;
        rom[4] = 16'h3480; rom[6] = 16'hFC00; rom[8] = 16'hFE00;

        rst_n = 1'b0;
        run = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_addr = 4'h0;
        model_reset();
        @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Start, then hold the first instruction for three cycles.
        step(1, 1, 0, 0);
        chk("latency_not_yet", 32'(inst_valid), 32'h0);
        step(0, 0, 0, 0);
        chk("first_inst", 32'(inst), 32'h1C0A);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("stall_inst", 32'(inst), 32'h1C0A);
            chk("stall_inst_pc", 32'(inst_pc), 32'h0);
            chk("stall_pc", 32'(pc), 32'h1);
        end
        step(0, 1, 0, 0);
        chk("seq_1", {16'(inst_pc), inst}, {16'h1, 16'h1E0B});
        step(0, 1, 0, 0);
        chk("seq_2", {16'(inst_pc), inst}, {16'h2, 16'h120A});
        step(0, 1, 0, 0);
        chk("seq_3", {16'(inst_pc), inst}, {16'h3, 16'h140A});

        // Redirect flush with same-cycle accept; FE00 also halts here.
        step(0, 1, 1, 4'h8);
        chk("flush_valid", 32'(inst_valid), 32'h0);
        step(0, 1, 0, 0);
        chk("redir_target", {16'(inst_pc), inst}, {16'h8, 16'hFE00});
        chk("halt_at_8", 32'(halted), 32'h1);
        step(0, 1, 0, 0);
        chk("halt_drained", 32'(inst_valid), 32'h0);

        // Wrap from 15 to 0.
        step(0, 1, 1, 4'hF);
        step(0, 1, 0, 0);
        chk("wrap_15", 32'(inst_pc), 32'hF);
        step(0, 1, 0, 0);
        chk("wrap_0", 32'(inst_pc), 32'h0);
        step(0, 1, 0, 0);
        chk("wrap_1", 32'(inst_pc), 32'h1);

        // Halt on FC00, hold while stalled, then restart from 0.
        step(0, 1, 1, 4'h6);
        step(0, 0, 0, 0);
        chk("halt_inst", {16'(inst_pc), inst}, {16'h6, 16'hFC00});
        chk("halted_6", 32'(halted), 32'h1);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("halt_no_fetch", {16'(pc), 15'h0, inst_valid}, {16'h6, 16'h0});
        step(0, 1, 1, 4'h0);
        step(0, 1, 0, 0);
        chk("restart", 32'(inst), 32'h1C0A);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
        end

        // Reset mid-transfer with a pending instruction.
        step(0, 1, 1, 4'h0);
        step(0, 0, 0, 0);
        chk("pre_reset_valid", 32'(inst_valid), 32'h1);
        #1;
        rst_n = 1'b0;
        run = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
        #1;
        check_reset_values("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("idle_after_reset", {16'(pc), 15'h0, inst_valid}, {16'h0, 16'h0});

`ifdef FETCH_SEQ_REDIRECT_CNT_EN
        for (int i = 0; i < 300; i++) step(0, 1, 1, 4'(i));
        chk("redirect_cnt_sat", 32'(redirect_cnt), 32'hFF);
`endif

        step(0, 0, 0, 0);
        @(negedge clk);
        #5;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
